db9_pad_scanner: RTL and testbench

- Multi-player DB9 pad scanner for the SNAC user port.
- Drives the select line (MDSEL) and the port multiplexer line (SPLIT), then samples the six shared active-low input pins.
- Auto-detects Atari-style, Mega Drive 3-button and 6-button pads per player, debounces the result and publishes 12-bit active-high button words to the core's input mapper.
- Generalises the fixed two-player scanner: configurable player count, scan timing, idle gap and debounce depth; adds pad-type reporting and a frame strobe.

---
 rtl/db9_pad_scanner.sv | 226 ++++++++++++++++++++++
 tb/tb_db9_pad_scanner.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/db9_pad_scanner.sv
// DB9 pad scanner for the SNAC user port: drives MDSEL/SPLIT, samples the
// shared pins, auto-detects Atari / MD 3-button / MD 6-button pads and debounces.
`timescale 1ns/1ps
module db9_pad_scanner #(
    parameter int PLAYERS    = 2,
    parameter int TICK_DIV   = 256,
    parameter int IDLE_STEPS = 160,
    parameter int DEBOUNCE   = 2
) (
    input  logic        I_CLK,
    input  logic        I_RESETn,
    input  logic        I_EN,
    input  logic [5:0]  I_JOY_IN,
    output logic        O_JOY_MDSEL,
    output logic        O_JOY_SPLIT,
    output logic [11:0] O_JOY1,
    output logic [11:0] O_JOY2,
    output logic [1:0]  O_TYPE1,
    output logic [1:0]  O_TYPE2,
    output logic        O_FRAME
);

    localparam int SW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int IW = (IDLE_STEPS > 1) ? $clog2(IDLE_STEPS) : 1;
    localparam int DW = $clog2(DEBOUNCE + 1);

    localparam logic [SW-1:0] STEP_LAST = SW'(TICK_DIV - 1);
    localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_STEPS - 1);
    localparam logic [DW-1:0] DB_MAX    = DW'(DEBOUNCE);
    localparam logic          P_LAST    = 1'(PLAYERS - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        PHASE,
        DECODE
    } state_t;

    state_t         state;
    logic [SW-1:0]  step;
    logic [IW-1:0]  idle_cnt;
    logic [2:0]     phase;
    logic           player;
    logic           mdsel;
    logic           split;
    logic           frame;

    logic [5:0]     sync1;
    logic [5:0]     sync2;
    logic [5:0]     pin;
    logic           step_last;

    logic [11:0]    raw   [2];
    logic           md    [2];
    logic           six   [2];
    logic [11:0]    prev  [2];
    logic [DW-1:0]  cnt   [2];
    logic [11:0]    word  [2];
    logic [1:0]     kind  [2];

    logic [11:0]    dec      [2];
    logic [1:0]     dtype    [2];
    logic [DW-1:0]  cnt_next [2];

    assign pin       = ~sync2;
    assign step_last = (step == STEP_LAST);

    always_ff @(posedge I_CLK or negedge I_RESETn) begin
        if (!I_RESETn) begin
            sync1 <= 6'h3F;
            sync2 <= 6'h3F;
        end else begin
            sync1 <= I_JOY_IN;
            sync2 <= sync1;
        end
    end

    // Decoded word depends on which identification phases answered.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            dec[i]      = {6'b0, raw[i][5:0]};
            dtype[i]    = 2'd0;
            cnt_next[i] = DW'(1);
            if (six[i]) begin
                dec[i]   = raw[i];
                dtype[i] = 2'd2;
            end else if (md[i]) begin
                dec[i]   = {4'b0, raw[i][7:0]};
                dtype[i] = 2'd1;
            end
            if (dec[i] == prev[i]) begin
                cnt_next[i] = (cnt[i] == DB_MAX) ? cnt[i] : cnt[i] + DW'(1);
            end
        end
    end

    always_ff @(posedge I_CLK or negedge I_RESETn) begin
        if (!I_RESETn) begin
            state    <= IDLE;
            step     <= '0;
            idle_cnt <= '0;
            phase    <= '0;
            player   <= 1'b0;
            mdsel    <= 1'b1;
            split    <= 1'b0;
            frame    <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                raw[i]  <= '0;
                md[i]   <= 1'b0;
                six[i]  <= 1'b0;
                prev[i] <= '0;
                cnt[i]  <= '0;
                word[i] <= '0;
                kind[i] <= '0;
            end
        end else if (!I_EN) begin
            state    <= IDLE;
            step     <= '0;
            idle_cnt <= '0;
            phase    <= '0;
            player   <= 1'b0;
            mdsel    <= 1'b1;
            split    <= 1'b0;
            frame    <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                prev[i] <= '0;
                cnt[i]  <= '0;
                word[i] <= '0;
                kind[i] <= '0;
            end
        end else begin
            frame <= 1'b0;
            step  <= step_last ? '0 : step + SW'(1);
            unique case (state)
                IDLE: begin
                    if (step_last) begin
                        if (idle_cnt == IDLE_LAST) begin
                            idle_cnt <= '0;
                            player   <= 1'b0;
                            split    <= 1'b0;
                            mdsel    <= 1'b1;
                            state    <= SETTLE;
                        end else begin
                            idle_cnt <= idle_cnt + IW'(1);
                        end
                    end
                end
                SETTLE: begin
                    if (step_last) begin
                        phase <= '0;
                        mdsel <= 1'b1;
                        state <= PHASE;
                    end
                end
                PHASE: begin
                    if (step_last) begin
                        case (phase)
                            3'd0: begin
                                raw[player][3] <= pin[0];
                                raw[player][2] <= pin[1];
                                raw[player][1] <= pin[2];
                                raw[player][0] <= pin[3];
                                raw[player][4] <= pin[4];
                                raw[player][5] <= pin[5];
                            end
                            3'd1: begin
                                raw[player][6] <= pin[4];
                                raw[player][7] <= pin[5];
                                md[player]     <= pin[2] & pin[3];
                            end
                            3'd5: begin
                                six[player] <= md[player] & (&pin[3:0]);
                            end
                            3'd6: begin
                                raw[player][11] <= pin[0];
                                raw[player][10] <= pin[1];
                                raw[player][9]  <= pin[2];
                                raw[player][8]  <= pin[3];
                            end
                            default: ;
                        endcase
                        if (phase == 3'd7) begin
                            mdsel <= 1'b1;
                            if (player == P_LAST) begin
                                split <= 1'b0;
                                state <= DECODE;
                            end else begin
                                player <= 1'b1;
                                split  <= 1'b1;
                                state  <= SETTLE;
                            end
                        end else begin
                            phase <= phase + 3'd1;
                            mdsel <= phase[0];
                        end
                    end
                end
                DECODE: begin
                    step <= '0;
                    for (int i = 0; i < 2; i++) begin
                        if (i < PLAYERS) begin
                            prev[i] <= dec[i];
                            cnt[i]  <= cnt_next[i];
                            if (cnt_next[i] == DB_MAX) begin
                                word[i] <= dec[i];
                                kind[i] <= dtype[i];
                            end
                        end
                    end
                    frame <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign O_JOY_MDSEL = mdsel;
    assign O_JOY_SPLIT = (PLAYERS > 1) ? split : 1'b0;
    assign O_JOY1      = word[0];
    assign O_JOY2      = (PLAYERS > 1) ? word[1] : 12'h000;
    assign O_TYPE1     = kind[0];
    assign O_TYPE2     = (PLAYERS > 1) ? kind[1] : 2'd0;
    assign O_FRAME     = frame;

endmodule

// File: tb/tb_db9_pad_scanner.sv
// Bench for db9_pad_scanner: pad models on both ports, frame scoreboard,
// timing monitors and a single-player instance.
`timescale 1ns/1ps
module tb_db9_pad_scanner;

    localparam int TICK   = 4;
    localparam int IDLE   = 2;
    localparam int DB     = 2;
    localparam int FRAME2 = (IDLE + 2 * 9) * TICK + 1;
    localparam int FRAME1 = (IDLE + 9) * TICK + 1;

    localparam int NONE  = 0;
    localparam int ATARI = 1;
    localparam int MD3   = 2;
    localparam int MD6   = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [5:0]  joy_in = 6'h3F;

    logic        mdsel, split, frame;
    logic [11:0] joy1, joy2;
    logic [1:0]  t1, t2;

    logic        mdsel_b, split_b, frame_b;
    logic [11:0] joy1_b, joy2_b;
    logic [1:0]  t1_b, t2_b;

    db9_pad_scanner #(
        .PLAYERS(2), .TICK_DIV(TICK), .IDLE_STEPS(IDLE), .DEBOUNCE(DB)
    ) dut (
        .I_CLK(clk), .I_RESETn(rst_n), .I_EN(en), .I_JOY_IN(joy_in),
        .O_JOY_MDSEL(mdsel), .O_JOY_SPLIT(split),
        .O_JOY1(joy1), .O_JOY2(joy2), .O_TYPE1(t1), .O_TYPE2(t2),
        .O_FRAME(frame)
    );

    db9_pad_scanner #(
        .PLAYERS(1), .TICK_DIV(TICK), .IDLE_STEPS(IDLE), .DEBOUNCE(DB)
    ) dut_b (
        .I_CLK(clk), .I_RESETn(rst_n), .I_EN(en), .I_JOY_IN(joy_in),
        .O_JOY_MDSEL(mdsel_b), .O_JOY_SPLIT(split_b),
        .O_JOY1(joy1_b), .O_JOY2(joy2_b), .O_TYPE1(t1_b), .O_TYPE2(t2_b),
        .O_FRAME(frame_b)
    );

    always #5 clk = ~clk;

    int applied = 0;
    int miscompares = 0;

    int          pty [2];
    logic [11:0] pbtn [2];

    // Pad model: counts MDSEL transitions, a long high level resets the count.
    int   t_cnt = 0;
    int   hi_cnt = 0;
    logic last_sel = 1'b1;

    function automatic logic [5:0] pad_pins(int ty, logic [11:0] b, logic sel, int t);
        logic [5:0] p;
        p = {b[5], b[4], b[0], b[1], b[2], b[3]};
        if (ty == NONE) begin
            p = '0;
        end else if (ty != ATARI) begin
            if (sel && ty == MD6 && t == 6)
                p[3:0] = {b[8], b[9], b[10], b[11]};
            else if (!sel && ty == MD6 && t == 5)
                p = {b[7], b[6], 4'hF};
            else if (!sel)
                p = {b[7], b[6], 2'b11, b[2], b[3]};
        end
        return ~p;
    endfunction

    always @(negedge clk) begin
        if (mdsel !== last_sel) begin
            t_cnt++;
            hi_cnt = 0;
        end else if (mdsel) begin
            hi_cnt++;
            if (hi_cnt >= 5) t_cnt = 0;
        end
        last_sel = mdsel;
        joy_in = split ? pad_pins(pty[1], pbtn[1], mdsel, t_cnt)
                       : pad_pins(pty[0], pbtn[0], mdsel, t_cnt);
    end

    // MDSEL low runs and SPLIT high runs while the monitor is armed.
    bit   mon_on = 1'b0;
    int   low_len = 0, split_len = 0;
    int   low_runs = 0, split_runs = 0, bad_runs = 0;
    logic prev_mdsel = 1'b1, prev_split = 1'b0;

    always @(negedge clk) begin
        if (mon_on) begin
            if (!mdsel) begin
                low_len++;
            end else if (!prev_mdsel) begin
                low_runs++;
                if (low_len != TICK) bad_runs++;
                low_len = 0;
            end
            if (split) begin
                split_len++;
            end else if (prev_split) begin
                split_runs++;
                if (split_len != 9 * TICK) bad_runs++;
                split_len = 0;
            end
        end
        prev_mdsel = mdsel;
        prev_split = split;
    end

    int b_bad = 0, b_cyc = 0, b_period = 0, b_frames = 0;

    always @(negedge clk) begin
        if (split_b !== 1'b0 || joy2_b !== 12'h000 || t2_b !== 2'd0) b_bad++;
        b_cyc++;
        if (frame_b === 1'b1) begin
            b_period = b_cyc;
            b_cyc = 0;
            b_frames++;
        end
    end

    typedef struct {
        logic [11:0] j1;
        logic [11:0] j2;
        logic [1:0]  k1;
        logic [1:0]  k2;
    } exp_t;

    exp_t sbq[$];

    logic [11:0] m_prev [2];
    logic [11:0] m_out  [2];
    logic [1:0]  m_kind [2];
    int          m_cnt  [2];

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        applied++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 2; i++) begin
            m_prev[i] = '0;
            m_out[i]  = '0;
            m_kind[i] = '0;
            m_cnt[i]  = 0;
        end
    endtask

    task automatic exp_dec(input int ty, input logic [11:0] b,
                           output logic [11:0] w, output logic [1:0] k);
        case (ty)
            ATARI:   begin w = b & 12'h03F; k = 2'd0; end
            MD3:     begin w = b & 12'h0FF; k = 2'd1; end
            MD6:     begin w = b;           k = 2'd2; end
            default: begin w = 12'h000;     k = 2'd0; end
        endcase
    endtask

    task automatic wait_frame(output int cyc, output bit ok);
        cyc = 0;
        ok = 1'b0;
        while (!ok && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (frame === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic run_frame(input string tag, output int cyc);
        exp_t        e;
        logic [11:0] w;
        logic [1:0]  k;
        bit          ok;
        for (int i = 0; i < 2; i++) begin
            exp_dec(pty[i], pbtn[i], w, k);
            if (w == m_prev[i]) m_cnt[i] = (m_cnt[i] >= DB) ? DB : m_cnt[i] + 1;
            else                m_cnt[i] = 1;
            m_prev[i] = w;
            if (m_cnt[i] == DB) begin
                m_out[i]  = w;
                m_kind[i] = k;
            end
        end
        e.j1 = m_out[0];
        e.j2 = m_out[1];
        e.k1 = m_kind[0];
        e.k2 = m_kind[1];
        sbq.push_back(e);
        wait_frame(cyc, ok);
        check({tag, "_frame_seen"}, 32'(ok), 32'd1);
        e = sbq.pop_front();
        check({tag, "_joy1"},  32'(joy1), 32'(e.j1));
        check({tag, "_joy2"},  32'(joy2), 32'(e.j2));
        check({tag, "_type1"}, 32'(t1),   32'(e.k1));
        check({tag, "_type2"}, 32'(t2),   32'(e.k2));
    endtask

    int cyc;

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        pty[0] = NONE;  pty[1] = NONE;
        pbtn[0] = '0;   pbtn[1] = '0;
        model_clear();
        repeat (3) @(negedge clk);
        check("rst_joy1",  32'(joy1),  32'h0);
        check("rst_joy2",  32'(joy2),  32'h0);
        check("rst_type1", 32'(t1),    32'h0);
        check("rst_type2", 32'(t2),    32'h0);
        check("rst_frame", 32'(frame), 32'h0);
        check("rst_mdsel", 32'(mdsel), 32'h1);
        check("rst_split", 32'(split), 32'h0);

        // Idle pins: timing of MDSEL, SPLIT and frames
        rst_n  = 1'b1;
        en     = 1'b1;
        mon_on = 1'b1;
        run_frame("t1_f1", cyc);
        check("t1_first_latency", 32'(cyc), 32'(FRAME2));
        run_frame("t1_f2", cyc);
        check("t1_period", 32'(cyc), 32'(FRAME2));
        @(negedge clk);
        mon_on = 1'b0;
        check("t1_bad_runs",   32'(bad_runs),   32'd0);
        check("t1_low_runs",   32'(low_runs),   32'd16);
        check("t1_split_runs", 32'(split_runs), 32'd2);

        // MD 3-button on port 1, A+Start
        pty[0] = MD3;
        pbtn[0] = 12'h0C0;
        run_frame("t2_f1", cyc);
        check("t2_joy1_one_frame", 32'(joy1), 32'h000);
        run_frame("t2_f2", cyc);
        check("t2_joy1", 32'(joy1), 32'h0C0);
        check("t2_type1", 32'(t1), 32'd1);

        // 6-button on port 2, Z+Mode
        pty[1] = MD6;
        pbtn[1] = 12'h900;
        run_frame("t3_f1", cyc);
        run_frame("t3_f2", cyc);
        check("t3_joy2", 32'(joy2), 32'h900);
        check("t3_type2", 32'(t2), 32'd2);
        check("t3_joy1_kept", 32'(joy1), 32'h0C0);

        // Atari stick on port 1, up+fire
        pty[0] = ATARI;
        pbtn[0] = 12'h018;
        run_frame("t4_f1", cyc);
        run_frame("t4_f2", cyc);
        check("t4_joy1", 32'(joy1), 32'h018);
        check("t4_type1", 32'(t1), 32'd0);

        // One-frame glitch on port 1
        pbtn[0] = 12'h019;
        run_frame("t5_glitch", cyc);
        pbtn[0] = 12'h018;
        run_frame("t5_f2", cyc);
        run_frame("t5_f3", cyc);
        check("t5_joy1_stable", 32'(joy1), 32'h018);

        // Enable dropped in the middle of player 1 phases
        repeat (24) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        check("t6_joy1",  32'(joy1),  32'h0);
        check("t6_joy2",  32'(joy2),  32'h0);
        check("t6_type1", 32'(t1),    32'h0);
        check("t6_type2", 32'(t2),    32'h0);
        check("t6_mdsel", 32'(mdsel), 32'h1);
        check("t6_split", 32'(split), 32'h0);
        check("t6_frame", 32'(frame), 32'h0);
        model_clear();
        repeat (10) @(negedge clk);
        en = 1'b1;
        run_frame("t6_f1", cyc);
        check("t6_reenable_latency", 32'(cyc), 32'(FRAME2));
        run_frame("t6_f2", cyc);
        check("t6_joy1_back", 32'(joy1), 32'h018);
        check("t6_joy2_back", 32'(joy2), 32'h900);

        // Single-player instance observations
        check("p1_split_joy2_bad", 32'(b_bad), 32'd0);
        check("p1_period", 32'(b_period), 32'(FRAME1));
        check("p1_frames_seen", 32'(b_frames >= 2), 32'd1);

        // Asynchronous reset in the middle of player 2 phases
        repeat (50) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("ar_joy1",  32'(joy1),  32'h0);
        check("ar_joy2",  32'(joy2),  32'h0);
        check("ar_type2", 32'(t2),    32'h0);
        check("ar_split", 32'(split), 32'h0);
        check("ar_mdsel", 32'(mdsel), 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        run_frame("ar_f1", cyc);
        check("ar_latency", 32'(cyc), 32'(FRAME2));

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
